// File: rtl/dec_state_invmixcol.sv
// AES decryption InvMixColumns stage: transforms WORDS_PER_CYCLE columns per BUSY cycle, in place.
// Latency 4/WORDS_PER_CYCLE cycles from accept to out_valid; valid/ready handshake on both sides.
module dec_state_invmixcol #(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state_in,
  input  logic         bypass_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] state_out,
  output logic         out_valid,
  input  logic         out_ready
);

  generate
    if (!(WORDS_PER_CYCLE == 1 || WORDS_PER_CYCLE == 2 || WORDS_PER_CYCLE == 4)) begin : g_bad_words
      $error("WORDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter step and the counter value whose BUSY edge covers column 3 (both modulo 4).
  localparam logic [1:0] STEP     = 2'(WORDS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - WORDS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q;
  logic [127:0] work_busy;
  logic         byp_q;
  logic [1:0]   cnt_q;
  logic         accept;
  logic [31:0]  cols [4];
  logic [31:0]  upd  [4];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2    = xt(s[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    for (int c = 0; c < 4; c++) cols[c] = work_q[127-32*c -: 32];
  end

  // Only the columns addressed by the counter are rewritten; the rest pass through.
  always_comb begin
    for (int c = 0; c < 4; c++) upd[c] = cols[c];
    for (int k = 0; k < WORDS_PER_CYCLE; k++)
      upd[2'(cnt_q + 2'(k))] = inv_mix_col(cols[2'(cnt_q + 2'(k))]);
    work_busy = {upd[0], upd[1], upd[2], upd[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= 128'h0;
      byp_q  <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (accept) begin
      work_q <= state_in;
      byp_q  <= bypass_in;
      cnt_q  <= 2'd0;
    end else if (state_q == BUSY) begin
      if (!byp_q) work_q <= work_busy;
      cnt_q <= cnt_q + STEP;
    end
  end

  assign state_out = work_q;

endmodule

// File: tb/tb_dec_state_invmixcol.sv
// Bench for dec_state_invmixcol: three instances (1, 2, 4 columns per cycle) checked against
// a GF(2^8) matrix-multiply model of (Inv)MixColumns.
module tb_dec_state_invmixcol;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] sin  [3];
  logic [127:0] sout [3];
  logic         bin  [3];
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dec_state_invmixcol #(.WORDS_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .state_in(sin[0]), .bypass_in(bin[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .state_out(sout[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  dec_state_invmixcol #(.WORDS_PER_CYCLE(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .state_in(sin[1]), .bypass_in(bin[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .state_out(sout[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  dec_state_invmixcol #(.WORDS_PER_CYCLE(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .state_in(sin[2]), .bypass_in(bin[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .state_out(sout[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int wpc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column; row r uses coefficient index (j - r) mod 4.
  function automatic logic [127:0] mat_state(input logic [127:0] s, input logic [31:0] k);
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(k[31-8*((j-row+4)%4) -: 8], s[127-32*c-8*j -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return mat_state(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    return mat_state(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic xact(input int i, input logic [127:0] d, input logic b,
                      input logic [127:0] exp, input string tag);
    int lat;
    @(negedge clk);
    sin[i] = d; bin[i] = b; iv[i] = 1'b1; ordy[i] = 1'b0;
    check({tag, " in_ready"}, 128'(ir[i]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv[i] = 1'b0;
    lat = 0;
    while (!ov[i] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(4 / wpc(i)));
    check({tag, " data"}, sout[i], exp);
    ordy[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[i] = 1'b0;
    check({tag, " idle out_valid"}, 128'(ov[i]), 128'd0);
    check({tag, " idle retain"}, sout[i], exp);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  initial begin
    logic [127:0] d, d2, exp;
    logic [127:0] data [8];
    logic [127:0] exp_q [$];
    int lat, sent, got, last_t, cyc;
    logic acc;

    for (int i = 0; i < 3; i++) begin
      sin[i] = '0; bin[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset out_valid w%0d", wpc(i)), 128'(ov[i]), 128'd0);
      check($sformatf("reset state_out w%0d", wpc(i)), sout[i], 128'h0);
      check($sformatf("reset in_ready w%0d", wpc(i)), 128'(ir[i]), 128'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      xact(i, FIPS_IN, 1'b0, FIPS_OUT, $sformatf("fips w%0d", wpc(i)));
      xact(i, FIPS_IN, 1'b1, FIPS_IN, $sformatf("bypass w%0d", wpc(i)));
    end

    // Backpressure in DONE, then simultaneous handoff and accept.
    d = rand128();
    exp = inv_model(d);
    @(negedge clk);
    sin[0] = d; bin[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sin[0] = rand128();
    check("bp busy in_ready", 128'(ir[0]), 128'd0);
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("bp latency", 128'(lat), 128'd4);
    for (int n = 0; n < 10; n++) begin
      check("bp hold data", sout[0], exp);
      check("bp hold out_valid", 128'(ov[0]), 128'd1);
      check("bp hold in_ready", 128'(ir[0]), 128'd0);
      @(posedge clk);
      @(negedge clk);
    end
    d2 = rand128();
    sin[0] = d2; ordy[0] = 1'b1; iv[0] = 1'b1;
    #1;
    check("bp handoff in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0; ordy[0] = 1'b0;
    check("bp after handoff out_valid", 128'(ov[0]), 128'd0);
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("bp second latency", 128'(lat), 128'd4);
    check("bp second data", sout[0], inv_model(d2));
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;

    // Streaming: 8 back-to-back states with the consumer always ready.
    for (int k = 0; k < 8; k++) data[k] = rand128();
    sent = 0; got = 0; last_t = -1; cyc = 0;
    ordy[0] = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (ov[0]) begin
        if (exp_q.size() == 0) check("stream unexpected output", sout[0], 128'hx);
        else check("stream data", sout[0], exp_q.pop_front());
        if (last_t >= 0) check("stream interval", 128'(cyc - last_t), 128'd5);
        last_t = cyc;
        got++;
      end
      iv[0] = (sent < 8);
      if (sent < 8) sin[0] = data[sent];
      bin[0] = 1'b0;
      acc = iv[0] && ir[0];
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(inv_model(data[sent]));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    check("stream count", 128'(got), 128'd8);

    // Reset after the second BUSY edge.
    d = rand128();
    @(negedge clk);
    sin[0] = d; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 128'(ov[0]), 128'd0);
    check("midreset state_out", sout[0], 128'h0);
    check("midreset in_ready", 128'(ir[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    d = rand128();
    xact(0, d, 1'b0, inv_model(d), "post reset");

    // Round trip: MixColumns in the model, InvMixColumns in the DUT.
    for (int n = 0; n < 1000; n++) begin
      d = rand128();
      xact(n % 3, mix_model(d), 1'b0, d, $sformatf("roundtrip w%0d", wpc(n % 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
